// File: rtl/proc_pkg.sv
// Shared processor definitions: control-word layout carried down the pipeline.
package proc_pkg;

    localparam int CTRL_W = 10;

    localparam int CTRL_SALTOINCOND = 9;
    localparam int CTRL_REGDEST     = 8;
    localparam int CTRL_FUENTEALU   = 7;
    localparam int CTRL_MEMAREG     = 6;
    localparam int CTRL_ESCRMEM     = 5;
    localparam int CTRL_LEERMEM     = 4;
    localparam int CTRL_ESCRREG     = 3;
    localparam int CTRL_SALTOCOND   = 2;
    localparam int CTRL_ALUOP_LSB   = 0;

    typedef logic [CTRL_W-1:0] ctrl_word_t;

endpackage

// File: rtl/mem_wb_stage_wb_select.sv
// Write-back data mux and register-file write qualification (register 0 is never written).
module wb_select #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              mema_reg_i,
    input  logic              escr_reg_i,
    input  logic              valid_i,
    input  logic [REG_AW-1:0] dest_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              wb_we_o
);

    assign wb_data_o = mema_reg_i ? mem_rdata_i : alu_result_i;
    assign wb_we_o   = valid_i & escr_reg_i & (dest_i != '0);

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with stall/flush control and a retired-writer counter.
module mem_wb_stage
    import proc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  ctrl_word_t        Control,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [REG_AW-1:0] dest_reg,
    output logic              MemaReg,
    output logic              EscrReg,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_dest,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_we,
    output logic [CNT_W-1:0]  retired_cnt
);

    logic              valid_q, valid_d;
    logic              mema_q, mema_d;
    logic              escr_q, escr_d;
    logic [REG_AW-1:0] dest_q, dest_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] mem_q, mem_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we;
    logic              retire;

    // The held instruction leaves on a flush or a normal advance, never under a plain stall.
    assign retire = we & (flush | ~stall);

    always_comb begin
        valid_d = valid_q;
        mema_d  = mema_q;
        escr_d  = escr_q;
        dest_d  = dest_q;
        alu_d   = alu_q;
        mem_d   = mem_q;
        cnt_d   = retire ? cnt_q + CNT_W'(1) : cnt_q;
        if (flush) begin
            valid_d = 1'b0;
            mema_d  = 1'b0;
            escr_d  = 1'b0;
        end else if (!stall) begin
            valid_d = in_valid;
            mema_d  = Control[CTRL_MEMAREG] & in_valid;
            escr_d  = Control[CTRL_ESCRREG] & in_valid;
            dest_d  = dest_reg;
            alu_d   = alu_result;
            mem_d   = mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            mema_q  <= 1'b0;
            escr_q  <= 1'b0;
            dest_q  <= '0;
            alu_q   <= '0;
            mem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            mema_q  <= mema_d;
            escr_q  <= escr_d;
            dest_q  <= dest_d;
            alu_q   <= alu_d;
            mem_q   <= mem_d;
            cnt_q   <= cnt_d;
        end
    end

    wb_select #(
        .DATA_W(DATA_W),
        .REG_AW(REG_AW)
    ) u_wb_select (
        .mema_reg_i  (mema_q),
        .escr_reg_i  (escr_q),
        .valid_i     (valid_q),
        .dest_i      (dest_q),
        .alu_result_i(alu_q),
        .mem_rdata_i (mem_q),
        .wb_data_o   (wb_data),
        .wb_we_o     (we)
    );

    assign MemaReg     = mema_q;
    assign EscrReg     = escr_q;
    assign wb_valid    = valid_q;
    assign wb_dest     = dest_q;
    assign wb_we       = we;
    assign retired_cnt = cnt_q;

endmodule
